// File: rtl/fifo_wr_ptr_full.sv
// Write-side pointer/flag controller of the async FIFO: binary/Gray write pointer, full, almost-full, level, overflow.
// Latency: W_EN/W_ADDR combinational; all flags, level and Gray pointer registered (1 CLK after W_INC/RD_PTR_GRAY_SYNC).
// Backpressure: FULL blocks writes (W_EN=0); a write attempted while FULL sets sticky OVERFLOW.
module fifo_wr_ptr_full #(
  parameter int ADDR_WIDTH = 3,
  parameter int AFULL_THR  = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  W_INC,
  input  logic [ADDR_WIDTH:0]   RD_PTR_GRAY_SYNC,
  input  logic                  OVF_CLR,
  output logic                  W_EN,
  output logic [ADDR_WIDTH-1:0] W_ADDR,
  output logic [ADDR_WIDTH:0]   WR_PTR_GRAY,
  output logic                  FULL,
  output logic                  ALMOST_FULL,
  output logic [ADDR_WIDTH:0]   W_LEVEL,
  output logic                  OVERFLOW
);

  localparam int PW = ADDR_WIDTH + 1;
  localparam logic [PW-1:0] AFULL_V = PW'(AFULL_THR);

  logic [PW-1:0] wbin;
  logic [PW-1:0] wbin_next;
  logic [PW-1:0] gray_next;
  logic [PW-1:0] rbin;
  logic [PW-1:0] level_next;
  logic          full_next;
  logic          ovf_set;

  assign W_EN      = W_INC & ~FULL;
  assign W_ADDR    = wbin[ADDR_WIDTH-1:0];
  assign wbin_next = wbin + {{ADDR_WIDTH{1'b0}}, W_EN};
  assign gray_next = wbin_next ^ (wbin_next >> 1);
  assign ovf_set   = W_INC & FULL;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PW; i++) begin
      rbin[i] = ^(RD_PTR_GRAY_SYNC >> i);
    end
  end

  // Full when the write pointer has lapped the read pointer: top two Gray bits inverted.
  assign full_next  = (gray_next == {~RD_PTR_GRAY_SYNC[PW-1:PW-2], RD_PTR_GRAY_SYNC[PW-3:0]});
  assign level_next = wbin_next - rbin;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      wbin        <= '0;
      WR_PTR_GRAY <= '0;
      FULL        <= 1'b0;
      ALMOST_FULL <= 1'b0;
      W_LEVEL     <= '0;
      OVERFLOW    <= 1'b0;
    end else begin
      wbin        <= wbin_next;
      WR_PTR_GRAY <= gray_next;
      FULL        <= full_next;
      ALMOST_FULL <= (level_next >= AFULL_V);
      W_LEVEL     <= level_next;
      if (ovf_set) begin
        OVERFLOW <= 1'b1;
      end else if (OVF_CLR) begin
        OVERFLOW <= 1'b0;
      end
    end
  end

endmodule
